// File: rtl/toeplitz_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : toeplitz_pkg
//  Description : Shared constants and state encoding for the Toeplitz hashing
//                pipeline (shift_seed / toeplitz_accum).
//  Revision    : 1.0 - initial release
// ============================================================================
package toeplitz_pkg;

    localparam int TPZ_WIDTH  = 3072;
    localparam int TPZ_N_ROWS = 4096;
    localparam int TPZ_OUT_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } accum_state_t;

endpackage
`default_nettype wire

// File: rtl/toeplitz_accum_if.sv
`default_nettype none
// ============================================================================
//  Interface   : toeplitz_accum_if
//  Description : Row-beat input bus and hash-word output stream of
//                toeplitz_accum, plus its status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface toeplitz_accum_if #(
    parameter int WIDTH = 3072,
    parameter int OUT_W = 32
);
    logic             frame_start;
    logic             sum_en;
    logic [WIDTH-1:0] shift_result;
    logic             key_bit;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output frame_start, sum_en, shift_result, key_bit, out_ready,
        input  out_valid, out_data, out_last, busy, done, err
    );

    modport slave (
        input  frame_start, sum_en, shift_result, key_bit, out_ready,
        output out_valid, out_data, out_last, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/toeplitz_accum.sv
`default_nettype none
// ============================================================================
//  Module      : toeplitz_accum
//  Description : GF(2) accumulation of key-selected Toeplitz rows into a hash
//                register, then word-serial drain over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module toeplitz_accum
    import toeplitz_pkg::*;
#(
    parameter int WIDTH  = TPZ_WIDTH,
    parameter int N_ROWS = TPZ_N_ROWS,
    parameter int OUT_W  = TPZ_OUT_W
) (
    input  wire logic         clk_in,
    input  wire logic         rst,
    toeplitz_accum_if.slave   bus
);

    localparam int c_words   = WIDTH / OUT_W;
    localparam int c_idx_w   = (c_words > 1) ? $clog2(c_words) : 1;
    localparam int c_cnt_w   = $clog2(N_ROWS + 1);
    localparam int c_pen_idx = (c_words > 1) ? (c_words - 2) : 0;

    localparam logic [c_cnt_w-1:0] c_last_row = c_cnt_w'(N_ROWS - 1);
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_words - 1);
    localparam logic [c_idx_w-1:0] c_pen_w    = c_idx_w'(c_pen_idx);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

    if ((WIDTH % OUT_W) != 0) begin : g_width_check
        $error("toeplitz_accum: WIDTH must be an integer multiple of OUT_W");
    end

    accum_state_t        r_state;
    logic [WIDTH-1:0]    r_acc;
    logic [c_cnt_w-1:0]  r_row_cnt;
    logic [c_idx_w-1:0]  r_word_idx;
    logic                r_out_valid;
    logic                r_out_last;
    logic                r_busy;
    logic                r_done;
    logic                r_err;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_row_cnt   <= '0;
            r_word_idx  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.frame_start) begin
                        r_acc     <= '0;
                        r_row_cnt <= '0;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ACCUM;
                    end else if (bus.sum_en) begin
                        r_err <= 1'b1;
                    end
                end

                ACCUM: begin
                    // A coincident beat is discarded: the restart takes priority.
                    if (bus.frame_start) begin
                        r_acc     <= '0;
                        r_row_cnt <= '0;
                    end else if (bus.sum_en) begin
                        if (bus.key_bit) begin
                            r_acc <= r_acc ^ bus.shift_result;
                        end
                        r_row_cnt <= r_row_cnt + c_cnt_one;
                        if (r_row_cnt == c_last_row) begin
                            r_state     <= DRAIN;
                            r_word_idx  <= '0;
                            r_out_valid <= 1'b1;
                            r_out_last  <= (c_words == 1);
                        end
                    end
                end

                DRAIN: begin
                    if (bus.sum_en) begin
                        r_err <= 1'b1;
                    end
                    if (bus.out_ready) begin
                        if (r_word_idx == c_last_idx) begin
                            r_state     <= IDLE;
                            r_word_idx  <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end else begin
                            r_word_idx <= r_word_idx + c_idx_one;
                            r_out_last <= (r_word_idx == c_pen_w);
                        end
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // Word mux reads only registered state, so it holds steady under backpressure.
    assign bus.out_data  = r_acc[r_word_idx * OUT_W +: OUT_W];
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_toeplitz_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_toeplitz_accum
//  Description : Scoreboard bench for toeplitz_accum (WIDTH=64, N_ROWS=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_toeplitz_accum;

    localparam int W  = 64;
    localparam int NR = 4;
    localparam int OW = 32;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    always #5 clk_in = ~clk_in;

    toeplitz_accum_if #(.WIDTH(W), .OUT_W(OW)) bus ();

    toeplitz_accum #(.WIDTH(W), .N_ROWS(NR), .OUT_W(OW)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct packed {
        logic [OW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          e;
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            stab_en  = 1'b0;
    bit            stalled  = 1'b0;
    logic [OW-1:0] held     = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [OW-1:0] d, input logic l);
        exp_t x;
        x.data = d;
        x.last = l;
        sb_q.push_back(x);
    endtask

    task automatic beat(input logic [W-1:0] row, input logic k);
        bus.sum_en       = 1'b1;
        bus.shift_result = row;
        bus.key_bit      = k;
        cyc();
        bus.sum_en       = 1'b0;
        bus.key_bit      = 1'b0;
        bus.shift_result = '0;
    endtask

    task automatic start();
        bus.frame_start = 1'b1;
        cyc();
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_done(input bit toggle);
        bit got = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (toggle) bus.out_ready = ~bus.out_ready;
            cyc();
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        check("done_seen", 64'(got), 64'd1);
        check("busy_at_done", 64'(bus.busy), 64'd0);
        check("valid_at_done", 64'(bus.out_valid), 64'd0);
    endtask

    // Monitor: pops the scoreboard on every handshake, independent of stimulus.
    initial begin : monitor
        forever begin
            @(negedge clk_in);
            if (stab_en && stalled) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_data", 64'(bus.out_data), 64'(held));
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = bus.out_data;
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word", bus.out_data);
                end else begin
                    e = sb_q.pop_front();
                    check("word_data", 64'(bus.out_data), 64'(e.data));
                    check("word_last", 64'(bus.out_last), 64'(e.last));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin : stimulus
        bus.frame_start  = 1'b0;
        bus.sum_en       = 1'b0;
        bus.shift_result = '0;
        bus.key_bit      = 1'b0;
        bus.out_ready    = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 rst = 1'b0;
        cyc();
        check("rst_valid", 64'(bus.out_valid), 64'd0);
        check("rst_last", 64'(bus.out_last), 64'd0);
        check("rst_data", 64'(bus.out_data), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);

        // Basic hash: 0x1 ^ 0x4 ^ 0x8 = 0xD
        start();
        check("busy_accum", 64'(bus.busy), 64'd1);
        beat(64'h1, 1'b1);
        beat(64'h2, 1'b0);
        beat(64'h4, 1'b1);
        check("valid_early", 64'(bus.out_valid), 64'd0);
        push(32'h0000000D, 1'b0);
        push(32'h00000000, 1'b1);
        bus.out_ready = 1'b1;
        beat(64'h8, 1'b1);
        check("valid_after_last_beat", 64'(bus.out_valid), 64'd1);
        wait_done(1'b0);

        // Backpressure: same frame, out_ready toggling
        bus.out_ready = 1'b0;
        start();
        beat(64'h1, 1'b1);
        beat(64'h2, 1'b0);
        beat(64'h4, 1'b1);
        beat(64'h8, 1'b1);
        push(32'h0000000D, 1'b0);
        push(32'h00000000, 1'b1);
        stab_en = 1'b1;
        wait_done(1'b1);
        stab_en = 1'b0;

        // Restart mid-frame with a coincident beat
        bus.out_ready = 1'b1;
        start();
        beat(64'hFF, 1'b1);
        beat(64'hFF, 1'b1);
        bus.frame_start  = 1'b1;
        bus.sum_en       = 1'b1;
        bus.shift_result = 64'hFF;
        bus.key_bit      = 1'b1;
        cyc();
        bus.frame_start  = 1'b0;
        bus.sum_en       = 1'b0;
        bus.key_bit      = 1'b0;
        beat(64'h10, 1'b1);
        beat(64'h20, 1'b1);
        beat(64'h40, 1'b1);
        push(32'h000000F0, 1'b0);
        push(32'h00000000, 1'b1);
        beat(64'h80, 1'b1);
        wait_done(1'b0);
        check("restart_err", 64'(bus.err), 64'd0);

        // Dropped beats in IDLE and DRAIN
        bus.out_ready = 1'b0;
        beat(64'hFFFF, 1'b1);
        check("err_idle_drop", 64'(bus.err), 64'd1);
        start();
        check("err_cleared", 64'(bus.err), 64'd0);
        beat(64'h3, 1'b1);
        beat(64'h5, 1'b1);
        beat(64'hF0, 1'b0);
        beat(64'hF00, 1'b0);
        beat(64'hFFFF, 1'b1);
        check("err_drain_drop", 64'(bus.err), 64'd1);
        push(32'h00000006, 1'b0);
        push(32'h00000000, 1'b1);
        bus.out_ready = 1'b1;
        wait_done(1'b0);
        check("err_sticky", 64'(bus.err), 64'd1);

        // Async reset in the middle of DRAIN
        bus.out_ready = 1'b0;
        start();
        beat(64'h11, 1'b1);
        beat(64'h22, 1'b1);
        beat(64'h44, 1'b1);
        beat(64'h88, 1'b1);
        push(32'h000000FF, 1'b0);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_err", 64'(bus.err), 64'd0);
        cyc();
        cyc();
        rst = 1'b0;
        cyc();
        start();
        beat(64'h100, 1'b1);
        beat(64'h200, 1'b0);
        beat(64'h400, 1'b1);
        beat(64'h800, 1'b0);
        push(32'h00000500, 1'b0);
        push(32'h00000000, 1'b1);
        bus.out_ready = 1'b1;
        wait_done(1'b0);

        cyc();
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
